// File: rtl/arf132b192e1r1w0cbbehcaa4acw_msff_pipe.sv
// Elastic DEPTH-stage register pipeline with per-side valid/ready, bubble collapse,
// synchronous flush, programmable reset value and a registered occupancy count.
module arf132b192e1r1w0cbbehcaa4acw_msff_pipe #(
    parameter int                DWIDTH  = 1,
    parameter int                DEPTH   = 2,
    parameter logic [DWIDTH-1:0] RST_VAL = '0,
    parameter int                OCCW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [DWIDTH-1:0] in_data,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [DWIDTH-1:0] out_data,
    output logic [OCCW-1:0]   occ
);

    logic [DEPTH-1:0]  vld;
    logic [DEPTH-1:0]  adv;
    logic [DEPTH-1:0]  load;
    logic [DWIDTH-1:0] dat [DEPTH];
    logic              accept;
    logic              emit;

    // Advance ripples from the output side so a full pipeline streams at full rate.
    always_comb begin
        adv            = '0;
        adv[DEPTH-1]   = vld[DEPTH-1] & out_rdy;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = vld[i] & (~vld[i+1] | adv[i+1]);
        end
    end

    assign in_rdy   = (~vld[0] | adv[0]) & ~flush & ~rst;
    assign out_vld  = vld[DEPTH-1] & ~flush & ~rst;
    assign out_data = dat[DEPTH-1];
    assign accept   = in_vld & in_rdy;
    assign emit     = out_vld & out_rdy;

    // A stage loads exactly when its upstream neighbour advances into it.
    always_comb begin
        load    = '0;
        load[0] = accept;
        for (int i = 1; i < DEPTH; i++) begin
            load[i] = adv[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            occ <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat[i] <= RST_VAL;
            end
        end else if (flush) begin
            vld <= '0;
            occ <= '0;
        end else begin
            if (load[0]) begin
                dat[0] <= in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (load[i]) begin
                    dat[i] <= dat[i-1];
                end
            end
            vld <= load | (vld & ~adv);
            case ({accept, emit})
                2'b10:   occ <= occ + OCCW'(1);
                2'b01:   occ <= occ - OCCW'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (occ == OCCW'($countones(vld)))
                else $error("occ out of step with valid stages");
            assert (occ <= OCCW'(DEPTH))
                else $error("occ exceeds depth");
            assert (!(emit && !accept && occ == '0))
                else $error("occ underflow");
            assert (!(accept && !emit && occ == OCCW'(DEPTH)))
                else $error("occ overflow");
        end
    end

endmodule

// File: tb/tb_arf132b192e1r1w0cbbehcaa4acw_msff_pipe.sv
// Directed checks on a DEPTH=3 pipeline, then randomized handshakes on DEPTH 3/1/2/5 copies.
module tb_arf132b192e1r1w0cbbehcaa4acw_msff_pipe;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_vld;
    logic [7:0] in_data;
    logic       out_rdy;

    logic       ir_a [4];
    logic       ov_a [4];
    logic [7:0] od_a [4];
    logic [2:0] oc_a [4];

    int         n_chk;
    int         n_bad;
    logic [7:0] mem  [4][16];
    int         wp   [4];
    int         rp   [4];
    logic       acc  [4];
    logic       emt  [4];
    logic [7:0] drain [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int D = (g == 0) ? 3 : (g == 1) ? 1 : (g == 2) ? 2 : 5;
        localparam int W = $clog2(D + 1);
        logic [W-1:0] occ_w;
        arf132b192e1r1w0cbbehcaa4acw_msff_pipe #(
            .DWIDTH (8),
            .DEPTH  (D),
            .RST_VAL(8'hA5)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .in_vld  (in_vld),
            .in_rdy  (ir_a[g]),
            .in_data (in_data),
            .out_vld (ov_a[g]),
            .out_rdy (out_rdy),
            .out_data(od_a[g]),
            .occ     (occ_w)
        );
        assign oc_a[g] = 3'(occ_w);
    end

    function automatic int dep_of(input int k);
        return (k == 0) ? 3 : (k == 1) ? 1 : (k == 2) ? 2 : 5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        in_vld  = v;
        in_data = d;
        out_rdy = r;
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst   = 1'b1;
        flush = 1'b0;
        drive(1'b1, 8'h77, 1'b1);

        // reset held two cycles with in_vld high
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("rst_in_rdy", ir_a[0], 0);
            chk("rst_out_vld", ov_a[0], 0);
            tick();
        end
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b1);
        #1;
        chk("post_rst_occ", oc_a[0], 0);
        chk("post_rst_data", od_a[0], 8'hA5);
        chk("post_rst_out_vld", ov_a[0], 0);
        chk("post_rst_in_rdy", ir_a[0], 1);
        tick();

        // streaming 0x01..0x10 with out_rdy high
        for (int c = 0; c < 20; c++) begin
            int a;
            int e;
            drive(c < 16, 8'(c + 1), 1'b1);
            #1;
            a = (c < 16) ? c : 16;
            e = (c < 3) ? 0 : ((c - 3 < 16) ? c - 3 : 16);
            chk("stream_in_rdy", ir_a[0], 1);
            chk("stream_out_vld", ov_a[0], (c >= 3 && c <= 18) ? 1 : 0);
            if (c >= 3 && c <= 18) chk("stream_data", od_a[0], c - 2);
            chk("stream_occ", oc_a[0], a - e);
            tick();
        end

        // back-pressure
        drive(1'b1, 8'h11, 1'b0); #1; chk("bp_fill_rdy", ir_a[0], 1); tick();
        drive(1'b1, 8'h22, 1'b0); #1; chk("bp_fill_rdy", ir_a[0], 1); tick();
        drive(1'b1, 8'h33, 1'b0); #1; chk("bp_fill_rdy", ir_a[0], 1); tick();
        drive(1'b1, 8'h44, 1'b0); #1;
        chk("bp_full_occ", oc_a[0], 3);
        chk("bp_full_in_rdy", ir_a[0], 0);
        chk("bp_full_out_vld", ov_a[0], 1);
        chk("bp_full_data", od_a[0], 8'h11);
        tick();
        drive(1'b1, 8'h44, 1'b0); #1; chk("bp_hold_data", od_a[0], 8'h11); tick();
        drive(1'b1, 8'h44, 1'b1); #1;
        chk("bp_release_in_rdy", ir_a[0], 1);
        chk("bp_release_data", od_a[0], 8'h11);
        tick();
        drive(1'b0, 8'h00, 1'b0); #1;
        chk("bp_after_occ", oc_a[0], 3);
        chk("bp_after_data", od_a[0], 8'h22);
        tick();
        drain[0] = 8'h22; drain[1] = 8'h33; drain[2] = 8'h44;
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 8'h00, 1'b1); #1;
            chk("bp_drain_vld", ov_a[0], 1);
            chk("bp_drain_data", od_a[0], drain[c]);
            tick();
        end
        drive(1'b0, 8'h00, 1'b1); #1;
        chk("bp_empty_occ", oc_a[0], 0);
        chk("bp_empty_vld", ov_a[0], 0);
        tick();

        // bubble collapse
        drive(1'b1, 8'h55, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0); tick();
        drive(1'b1, 8'h66, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0); #1;
        chk("bub_occ", oc_a[0], 2);
        chk("bub_out_vld", ov_a[0], 1);
        chk("bub_data", od_a[0], 8'h55);
        tick();
        drive(1'b0, 8'h00, 1'b1); #1;
        chk("bub_first_vld", ov_a[0], 1);
        chk("bub_first_data", od_a[0], 8'h55);
        tick();
        drive(1'b0, 8'h00, 1'b1); #1;
        chk("bub_second_vld", ov_a[0], 1);
        chk("bub_second_data", od_a[0], 8'h66);
        tick();
        drive(1'b0, 8'h00, 1'b1); #1;
        chk("bub_empty_vld", ov_a[0], 0);
        chk("bub_empty_occ", oc_a[0], 0);
        tick();

        // flush with in_vld and out_rdy both high
        drive(1'b1, 8'h77, 1'b0); tick();
        drive(1'b1, 8'h88, 1'b0); tick();
        drive(1'b1, 8'h99, 1'b1);
        flush = 1'b1;
        #1;
        chk("fl_occ_before", oc_a[0], 2);
        chk("fl_in_rdy", ir_a[0], 0);
        chk("fl_out_vld", ov_a[0], 0);
        tick();
        flush = 1'b0;
        drive(1'b0, 8'h00, 1'b1); #1;
        chk("fl_occ_after", oc_a[0], 0);
        chk("fl_out_vld_after", ov_a[0], 0);
        chk("fl_data_held", od_a[0], 8'h66);
        tick();
        drive(1'b1, 8'hAB, 1'b1); tick();
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 8'h00, 1'b1); #1;
            chk("fl_no_stale", ov_a[0], 0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b1); #1;
        chk("fl_new_vld", ov_a[0], 1);
        chk("fl_new_data", od_a[0], 8'hAB);
        tick();

        // randomized handshakes against a per-instance scoreboard
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wp[k] = 0;
            rp[k] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            drive($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1);
            #1;
            for (int k = 0; k < 4; k++) begin
                int cnt;
                cnt = wp[k] - rp[k];
                chk($sformatf("rnd_d%0d_occ", dep_of(k)), oc_a[k], cnt);
                chk($sformatf("rnd_d%0d_in_rdy", dep_of(k)), ir_a[k],
                    (cnt < dep_of(k) || out_rdy) ? 1 : 0);
                if (cnt == 0)
                    chk($sformatf("rnd_d%0d_vld_empty", dep_of(k)), ov_a[k], 0);
                else if (ov_a[k])
                    chk($sformatf("rnd_d%0d_data", dep_of(k)), od_a[k], mem[k][rp[k] % 16]);
                acc[k] = in_vld & ir_a[k];
                emt[k] = ov_a[k] & out_rdy;
                if (acc[k]) mem[k][wp[k] % 16] = in_data;
            end
            tick();
            for (int k = 0; k < 4; k++) begin
                if (acc[k]) wp[k]++;
                if (emt[k]) rp[k]++;
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
